// File: rtl/iter_multiplier.sv
// Iterative 32x32 shift-add multiplier with HI/LO result registers for mult/multu.
// Falling-edge clocked to line up with the neg-edged datapath registers.
module iter_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   addend_c;
  logic [WIDTH:0]     sum_c;
  logic [ACC_W-1:0]   product_c;
  logic [WIDTH-1:0]   abs_a_c;
  logic [WIDTH-1:0]   abs_b_c;

  // One partial-product step on the upper half, keeping the carry for the shift
  always_comb begin
    addend_c  = mplier_q[0] ? mcand_q : '0;
    sum_c     = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, addend_c};
    product_c = neg_q ? (~acc_q + ACC_W'(1)) : acc_q;
    abs_a_c   = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    abs_b_c   = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = done_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          mcand_d  = abs_a_c;
          mplier_d = abs_b_c;
          neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = {sum_c, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        {hi_d, lo_d} = product_c;
        done_d       = 1'b1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset aborts any in-flight operation before it can reach hi/lo
  always_ff @(negedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
